// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle SHL/SHR/SHRA/ROL/ROR unit with a double-width result on {z_high,z_low}.
// Define SEQ_SHIFT_FAST_EN to replace the STEP-per-cycle RUN phase with a single-cycle barrel network.
module seq_shift_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] shifts,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_low,
  output logic [WIDTH-1:0] z_high
);

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  typedef int unsigned uint_t;

  state_t           state, state_d;
  logic [AMT_W-1:0] amt;
  logic             accept;
  logic             unused_shift_bits;

  assign amt               = shifts[AMT_W-1:0];
  assign unused_shift_bits = ^shifts[WIDTH-1:AMT_W];

  // Shifts the pair by s; right shifts treat z_low as the upper half so spilled bits land MSB-first in z_high.
  function automatic logic [2*WIDTH-1:0] shift_pair(input logic [2:0]       f,
                                                     input logic [WIDTH-1:0] lo,
                                                     input logic [WIDTH-1:0] hi,
                                                     input logic [AMT_W-1:0] s);
    logic [2*WIDTH-1:0] t;
    logic [2*WIDTH-1:0] r;
    uint_t              rot;
    rot = uint_t'(s) % WIDTH;
    t   = '0;
    r   = '0;
    case (f)
      OP_SHL:  r = {hi, lo} << s;
      OP_SHR: begin
        t = {lo, hi} >> s;
        r = {t[WIDTH-1:0], t[2*WIDTH-1:WIDTH]};
      end
      OP_SHRA: begin
        t = $signed({lo, hi}) >>> s;
        r = {t[WIDTH-1:0], t[2*WIDTH-1:WIDTH]};
      end
      OP_ROL: begin
        t = {lo, lo} << rot;
        r = {{WIDTH{1'b0}}, t[2*WIDTH-1:WIDTH]};
      end
      OP_ROR: begin
        t = {lo, lo} >> rot;
        r = {{WIDTH{1'b0}}, t[WIDTH-1:0]};
      end
      default: r = {hi, lo};
    endcase
    return r;
  endfunction

`ifndef SEQ_SHIFT_FAST_EN
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  logic [2:0]       op_q;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] step_s;

  assign step_s = (count < STEP_A) ? count : STEP_A;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          accept = 1'b1;
`ifdef SEQ_SHIFT_FAST_EN
          state_d = S_FIN;
`else
          state_d = (amt == '0 || op > OP_ROR) ? S_FIN : S_RUN;
`endif
        end
      end
      S_RUN: begin
`ifndef SEQ_SHIFT_FAST_EN
        if (count == step_s) state_d = S_FIN;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);

`ifdef SEQ_SHIFT_FAST_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_low  <= '0;
      z_high <= '0;
    end else if (accept) begin
      {z_high, z_low} <= shift_pair(op, in1, '0, amt);
    end
  end
`else
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      z_low  <= '0;
      z_high <= '0;
      op_q   <= '0;
      count  <= '0;
    end else if (accept) begin
      z_low  <= in1;
      z_high <= '0;
      op_q   <= op;
      count  <= amt;
    end else if (state == S_RUN) begin
      {z_high, z_low} <= shift_pair(op_q, z_low, z_high, step_s);
      count           <= count - step_s;
    end
  end
`endif

endmodule
